// File: rtl/rr_tick_arbiter.sv
// rr_tick_arbiter: round-robin owner of one shared rollover counter.
// Each grant holds the counter enable until the owner has seen its requested
// number of rollovers, then pulses done and hands priority to the next index.
// Latency: request in IDLE -> grant next cycle; final rollover -> done next
// cycle; two dead cycles (DONE, IDLE) between consecutive grants.
// Backpressure: none; requests are level-held and non-owners simply wait.
// Optional macro RR_TICK_ARB_TIMEOUT_EN adds a per-grant watchdog (err pulse).
// Ports:
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_req, i_req_len      per-requester request level and rollover count
//   o_gnt, o_done, o_err  one-hot grant, completion pulse, watchdog pulse
//   o_busy                high whenever not IDLE
//   o_cnt_enable          enable to the shared counter (== OR of o_gnt)
//   i_cnt_rollover        rollover from the shared counter
module rr_tick_arbiter #(
  parameter int N_REQ          = 4,
  parameter int LEN_W          = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic [N_REQ-1:0]       i_req,
  input  logic [N_REQ*LEN_W-1:0] i_req_len,
  output logic [N_REQ-1:0]       o_gnt,
  output logic [N_REQ-1:0]       o_done,
  output logic                   o_err,
  output logic                   o_busy,
  output logic                   o_cnt_enable,
  input  logic                   i_cnt_rollover
);

  localparam int PTR_W = $clog2(N_REQ);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [PTR_W-1:0] r_ptr, w_ptr_nxt;
  logic [PTR_W-1:0] r_owner, w_owner_nxt;
  logic [LEN_W-1:0] r_remaining, w_remaining_nxt;
  logic [N_REQ-1:0] r_gnt, w_gnt_nxt;
  logic [N_REQ-1:0] r_done, w_done_nxt;

  logic             w_found;
  logic [PTR_W-1:0] w_win;
  logic [PTR_W-1:0] w_scan;
  logic [LEN_W-1:0] w_win_len;
  logic [PTR_W-1:0] w_owner_inc;
  logic             w_counted;

  // Rollovers only count while this arbiter actually enables the counter.
  assign w_counted   = i_cnt_rollover & o_cnt_enable;
  assign w_owner_inc = (r_owner == PTR_W'(N_REQ-1)) ? '0 : r_owner + 1'b1;

  // Scan upward from the priority pointer with wrap; first requester wins.
  always_comb begin
    w_found   = 1'b0;
    w_win     = r_ptr;
    w_scan    = r_ptr;
    w_win_len = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!w_found && i_req[w_scan]) begin
        w_found = 1'b1;
        w_win   = w_scan;
      end
      w_scan = (w_scan == PTR_W'(N_REQ-1)) ? '0 : w_scan + 1'b1;
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (w_win == PTR_W'(i)) begin
        w_win_len = i_req_len[i*LEN_W +: LEN_W];
      end
    end
  end

`ifdef RR_TICK_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES+1);
  logic [WD_W-1:0] r_wdog, w_wdog_nxt;
  logic            r_err, w_err_nxt;
  assign o_err = r_err;
`else
  // The watchdog limit only matters when the watchdog is built in.
  logic w_unused_tmo;
  assign w_unused_tmo = (TIMEOUT_CYCLES != 0);
  assign o_err = 1'b0;
`endif

  always_comb begin
    w_state_nxt     = r_state;
    w_ptr_nxt       = r_ptr;
    w_owner_nxt     = r_owner;
    w_remaining_nxt = r_remaining;
    w_gnt_nxt       = r_gnt;
    w_done_nxt      = '0;
`ifdef RR_TICK_ARB_TIMEOUT_EN
    w_wdog_nxt      = r_wdog;
    w_err_nxt       = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt     = S_GRANT;
          w_owner_nxt     = w_win;
          w_gnt_nxt       = N_REQ'(1) << w_win;
          // A zero length still means one rollover.
          w_remaining_nxt = (w_win_len == '0) ? LEN_W'(1) : w_win_len;
`ifdef RR_TICK_ARB_TIMEOUT_EN
          w_wdog_nxt      = '0;
`endif
        end
      end
      S_GRANT: begin
        if (!i_req[r_owner]) begin
          // Abort: a dropped request beats a simultaneous final rollover.
          w_state_nxt     = S_DONE;
          w_gnt_nxt       = '0;
          w_ptr_nxt       = w_owner_inc;
          w_remaining_nxt = '0;
        end else if (w_counted && (r_remaining == LEN_W'(1))) begin
          w_state_nxt     = S_DONE;
          w_gnt_nxt       = '0;
          w_done_nxt      = r_gnt;
          w_ptr_nxt       = w_owner_inc;
          w_remaining_nxt = '0;
`ifdef RR_TICK_ARB_TIMEOUT_EN
        end else if (!w_counted && (r_wdog == WD_W'(TIMEOUT_CYCLES))) begin
          w_state_nxt     = S_DONE;
          w_gnt_nxt       = '0;
          w_err_nxt       = 1'b1;
          w_ptr_nxt       = w_owner_inc;
          w_remaining_nxt = '0;
`endif
        end else begin
          if (w_counted && (r_remaining != '0)) begin
            w_remaining_nxt = r_remaining - LEN_W'(1);
          end
`ifdef RR_TICK_ARB_TIMEOUT_EN
          w_wdog_nxt = w_counted ? '0 : r_wdog + 1'b1;
`endif
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_gnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_owner     <= '0;
      r_remaining <= '0;
      r_gnt       <= '0;
      r_done      <= '0;
`ifdef RR_TICK_ARB_TIMEOUT_EN
      r_wdog      <= '0;
      r_err       <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_owner     <= w_owner_nxt;
      r_remaining <= w_remaining_nxt;
      r_gnt       <= w_gnt_nxt;
      r_done      <= w_done_nxt;
`ifdef RR_TICK_ARB_TIMEOUT_EN
      r_wdog      <= w_wdog_nxt;
      r_err       <= w_err_nxt;
`endif
    end
  end

  assign o_gnt        = r_gnt;
  assign o_done       = r_done;
  assign o_busy       = (r_state != S_IDLE);
  assign o_cnt_enable = |r_gnt;

endmodule

// File: tb/tb_rr_tick_arbiter.sv
// Bench for rr_tick_arbiter: directed scenario tables plus a random run, all
// compared cycle by cycle against a transaction-style reference model.
module tb_rr_tick_arbiter;
  localparam int N   = 4;
  localparam int LW  = 8;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  req = '0;
  logic [N*LW-1:0] req_len = '0;
  logic          roll = 1'b0;
  logic [N-1:0]  gnt, done;
  logic          err, busy, en;

  always #5 clk = ~clk;

  rr_tick_arbiter #(.N_REQ(N), .LEN_W(LW), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clk(clk), .i_reset(reset), .i_req(req), .i_req_len(req_len),
    .o_gnt(gnt), .o_done(done), .o_err(err), .o_busy(busy),
    .o_cnt_enable(en), .i_cnt_rollover(roll)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  wire  [2*N+2:0] obs = {gnt, done, err, busy, en};
  logic [2*N+2:0] exp_v;

  // Reference model: who owns the counter, how many rollovers it still
  // needs, and how many no-arbitration cycles follow a finished grant.
  int m_owner = -1, m_left = 0, m_dead = 0, m_ptr = 0, m_wd = 0;

  task automatic model_step();
    logic [N-1:0] d;
    logic e;
    bit fin;
    d = '0; e = 1'b0; fin = 0;
    if (reset) begin
      m_owner = -1; m_left = 0; m_dead = 0; m_ptr = 0; m_wd = 0;
    end else if (m_owner >= 0) begin
      if (!req[m_owner]) fin = 1;
      else if (roll && m_left == 1) begin d[m_owner] = 1'b1; fin = 1; end
`ifdef RR_TICK_ARB_TIMEOUT_EN
      else if (!roll && m_wd == TMO) begin e = 1'b1; fin = 1; end
`endif
      else begin
        if (roll) begin m_left--; m_wd = 0; end
        else m_wd++;
      end
      if (fin) begin m_ptr = (m_owner + 1) % N; m_owner = -1; m_dead = 1; end
    end else if (m_dead > 0) begin
      m_dead--;
    end else begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_ptr + k) % N;
        if (m_owner < 0 && req[i]) begin
          m_owner = i;
          m_left  = int'(req_len[i*LW +: LW]);
          if (m_left == 0) m_left = 1;
          m_wd = 0;
        end
      end
    end
    exp_v = {(m_owner >= 0) ? (N'(1) << m_owner) : N'(0), d, e,
             (m_owner >= 0 || m_dead > 0), (m_owner >= 0)};
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    cyc++;
    #1;
  endtask

  task automatic set_len(input int i, input int v);
    req_len[i*LW +: LW] = LW'(v);
  endtask

  typedef struct {
    bit           rst;
    logic [N-1:0] rq;
    bit           rl;
    int           len2;
    logic [N-1:0] g;
    logic [N-1:0] d;
  } step_t;

  task automatic test_reset();
    reset = 1'b1; req = '0; roll = 1'b0; req_len = '0;
    tick(); tick();
    checks++;
    if (obs !== '0) begin errors++; $display("FAIL reset_outputs got=%b exp=0", obs); end
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL reset_model got=%b exp=%b", obs, exp_v); end
    reset = 1'b0;
  endtask

  task automatic test_single();
    int en_cnt = 0, n_roll = 0;
    bit seen = 0;
    req = 4'b0010; set_len(1, 3); roll = 1'b0;
    tick();
    checks++;
    if (gnt !== 4'b0010) begin errors++; $display("FAIL single_gnt got=%b exp=0010", gnt); end
    for (int c = 0; c < 60 && !seen; c++) begin
      roll = en && (en_cnt % 4 == 3);
      if (en) en_cnt++;
      if (roll) n_roll++;
      tick();
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL single_model cyc=%0d got=%b exp=%b", cyc, obs, exp_v); end
      if (done !== 4'b0000) begin
        seen = 1;
        checks++;
        if (done !== 4'b0010 || n_roll != 3 || en !== 1'b0 || gnt !== 4'b0000) begin
          errors++;
          $display("FAIL single_done got done=%b rolls=%0d en=%b gnt=%b exp done=0010 rolls=3 en=0 gnt=0000",
                   done, n_roll, en, gnt);
        end
      end
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL single_timeout got=no done exp=done[1]"); end
    roll = 1'b0; req = '0;
    tick(); tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL single_idle got busy=%b exp=0", busy); end
  endtask

  task automatic test_round_robin();
    int order[$];
    int gaps[$];
    int idle_run = 0;
    logic [N-1:0] prev = '0;
    reset = 1'b1; req = '0; roll = 1'b0;
    tick();
    reset = 1'b0;
    for (int i = 0; i < N; i++) set_len(i, 1);
    req = 4'b1111; roll = 1'b1;
    for (int c = 0; c < 60 && order.size() < 5; c++) begin
      tick();
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL rr_model cyc=%0d got=%b exp=%b", cyc, obs, exp_v); end
      if (gnt != 0 && prev == 0) begin
        for (int i = 0; i < N; i++) if (gnt[i]) order.push_back(i);
        gaps.push_back(idle_run);
        idle_run = 0;
      end
      if (gnt == 0) idle_run++;
      prev = gnt;
    end
    checks++;
    if (order.size() != 5) begin
      errors++; $display("FAIL rr_count got=%0d exp=5", order.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (order[k] != k % N) begin errors++; $display("FAIL rr_order k=%0d got=%0d exp=%0d", k, order[k], k % N); end
        if (k > 0) begin
          checks++;
          if (gaps[k] != 2) begin errors++; $display("FAIL rr_gap k=%0d got=%0d exp=2", k, gaps[k]); end
        end
      end
    end
    tick();
    checks++;
    if (done !== 4'b0001) begin errors++; $display("FAIL rr_last_done got=%b exp=0001", done); end
    req = '0; roll = 1'b0;
    tick();
  endtask

  task automatic test_zero_len_wrap();
    step_t t[9];
    for (int i = 0; i < N; i++) set_len(i, 1);
    set_len(3, 0);
    t = '{'{0, 4'b0100, 0, 1, 4'b0100, 4'b0000},
          '{0, 4'b0100, 1, 1, 4'b0000, 4'b0100},
          '{0, 4'b0000, 0, 1, 4'b0000, 4'b0000},
          '{0, 4'b1111, 0, 1, 4'b1000, 4'b0000},
          '{0, 4'b1111, 1, 1, 4'b0000, 4'b1000},
          '{0, 4'b1111, 0, 1, 4'b0000, 4'b0000},
          '{0, 4'b1111, 1, 1, 4'b0001, 4'b0000},
          '{0, 4'b1111, 1, 1, 4'b0000, 4'b0001},
          '{0, 4'b0000, 0, 1, 4'b0000, 4'b0000}};
    for (int s = 0; s < 9; s++) begin
      req = t[s].rq; roll = t[s].rl;
      tick();
      checks++;
      if (gnt !== t[s].g || done !== t[s].d) begin
        errors++; $display("FAIL wrap_step%0d got gnt=%b done=%b exp gnt=%b done=%b", s, gnt, done, t[s].g, t[s].d);
      end
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL wrap_model step%0d got=%b exp=%b", s, obs, exp_v); end
    end
  endtask

  task automatic test_abort();
    step_t t[14];
    // Step 1 lowers len[2] mid-grant; it must not shorten the grant.
    t = '{'{0, 4'b0100, 0, 5, 4'b0100, 4'b0000},
          '{0, 4'b0100, 1, 1, 4'b0100, 4'b0000},
          '{0, 4'b0000, 0, 5, 4'b0000, 4'b0000},
          '{0, 4'b0000, 0, 5, 4'b0000, 4'b0000},
          '{0, 4'b1111, 0, 5, 4'b1000, 4'b0000},
          '{0, 4'b0000, 0, 5, 4'b0000, 4'b0000},
          '{0, 4'b0000, 0, 5, 4'b0000, 4'b0000},
          '{0, 4'b0100, 0, 2, 4'b0100, 4'b0000},
          '{0, 4'b0100, 1, 2, 4'b0100, 4'b0000},
          '{0, 4'b0000, 1, 2, 4'b0000, 4'b0000},
          '{0, 4'b0000, 0, 2, 4'b0000, 4'b0000},
          '{0, 4'b1111, 0, 2, 4'b1000, 4'b0000},
          '{0, 4'b1111, 1, 2, 4'b0000, 4'b1000},
          '{0, 4'b0000, 0, 2, 4'b0000, 4'b0000}};
    for (int s = 0; s < 14; s++) begin
      req = t[s].rq; roll = t[s].rl; set_len(2, t[s].len2);
      tick();
      checks++;
      if (gnt !== t[s].g || done !== t[s].d) begin
        errors++; $display("FAIL abort_step%0d got gnt=%b done=%b exp gnt=%b done=%b", s, gnt, done, t[s].g, t[s].d);
      end
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL abort_model step%0d got=%b exp=%b", s, obs, exp_v); end
    end
  endtask

  task automatic test_reset_mid();
    step_t t[15];
    set_len(0, 1);
    t = '{'{0, 4'b0100, 0, 6, 4'b0100, 4'b0000},
          '{0, 4'b0100, 1, 6, 4'b0100, 4'b0000},
          '{0, 4'b0100, 1, 6, 4'b0100, 4'b0000},
          '{1, 4'b0100, 0, 6, 4'b0000, 4'b0000},
          '{0, 4'b0101, 0, 6, 4'b0001, 4'b0000},
          '{0, 4'b0101, 1, 6, 4'b0000, 4'b0001},
          '{0, 4'b0101, 0, 6, 4'b0000, 4'b0000},
          '{0, 4'b0101, 0, 6, 4'b0100, 4'b0000},
          '{0, 4'b0101, 1, 6, 4'b0100, 4'b0000},
          '{0, 4'b0101, 1, 6, 4'b0100, 4'b0000},
          '{0, 4'b0101, 1, 6, 4'b0100, 4'b0000},
          '{0, 4'b0101, 1, 6, 4'b0100, 4'b0000},
          '{0, 4'b0101, 1, 6, 4'b0100, 4'b0000},
          '{0, 4'b0101, 1, 6, 4'b0000, 4'b0100},
          '{0, 4'b0000, 0, 6, 4'b0000, 4'b0000}};
    for (int s = 0; s < 15; s++) begin
      reset = t[s].rst; req = t[s].rq; roll = t[s].rl; set_len(2, t[s].len2);
      tick();
      checks++;
      if (gnt !== t[s].g || done !== t[s].d) begin
        errors++; $display("FAIL rstmid_step%0d got gnt=%b done=%b exp gnt=%b done=%b", s, gnt, done, t[s].g, t[s].d);
      end
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL rstmid_model step%0d got=%b exp=%b", s, obs, exp_v); end
      if (t[s].rst) begin
        checks++;
        if (obs !== '0) begin errors++; $display("FAIL rstmid_clear got=%b exp=0", obs); end
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_timeout();
    int err_at = -1;
    req = 4'b0001; set_len(0, 1); roll = 1'b0;
    tick();
    checks++;
    if (gnt !== 4'b0001) begin errors++; $display("FAIL tmo_gnt got=%b exp=0001", gnt); end
`ifdef RR_TICK_ARB_TIMEOUT_EN
    for (int t = 1; t <= 40 && err_at < 0; t++) begin
      tick();
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL tmo_model t=%0d got=%b exp=%b", t, obs, exp_v); end
      if (err === 1'b1) begin
        err_at = t;
        checks++;
        if (done !== 4'b0000) begin errors++; $display("FAIL tmo_done got=%b exp=0000", done); end
      end
    end
    checks++;
    if (err_at != 17) begin errors++; $display("FAIL tmo_err_time got=%0d exp=17", err_at); end
    req = '0;
    tick(); tick();
`else
    for (int t = 1; t <= 40; t++) begin
      tick();
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL hold_model t=%0d got=%b exp=%b", t, obs, exp_v); end
      if (err !== 1'b0 || gnt !== 4'b0001) err_at = t;
    end
    checks++;
    if (err_at >= 0) begin errors++; $display("FAIL hold_grant first_bad_cycle got=%0d exp=none", err_at); end
    req = '0;
    tick();
    checks++;
    if (done !== 4'b0000 || busy !== 1'b1) begin
      errors++; $display("FAIL hold_abort got done=%b busy=%b exp done=0000 busy=1", done, busy);
    end
    tick();
`endif
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
        set_len(i, $urandom_range(0, 3));
      end
      roll  = $urandom_range(0, 1) == 1;
      reset = $urandom_range(0, 99) == 0;
      tick();
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL random_model cyc=%0d got=%b exp=%b", cyc, obs, exp_v); end
    end
    reset = 1'b0; req = '0; roll = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_zero_len_wrap();
    test_abort();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
